sparse_index_encoder: RTL and testbench



---
 rtl/bitfuscnn_pkg.sv | 22 ++
 rtl/sparse_index_encoder_run_counter.sv | 72 +++++++
 rtl/sparse_index_encoder.sv | 97 +++++++++
 tb/tb_sparse_index_encoder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitfuscnn_pkg.sv
// Shared types and helpers for the sparse (zero-run-length) tile format.
package bitfuscnn_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned LANES  = 16;
  localparam int unsigned IDX_W  = 4;

  typedef struct packed {
    logic [DATA_W-1:0] value;
    logic [IDX_W-1:0]  index;
  } sparse_entry_t;

  // Lanes per output group for a bitwidth code; unknown codes fall back to 16.
  function automatic logic [4:0] group_size(input logic [3:0] bitwidth);
    case (bitwidth)
      4'd2:    return 5'd8;
      4'd3:    return 5'd4;
      default: return 5'd16;
    endcase
  endfunction

endpackage

// File: rtl/sparse_index_encoder_run_counter.sv
// Tracks the run index for the next entry, the current lane and the latched group size.
module sparse_run_counter
  import bitfuscnn_pkg::group_size;
#(
  parameter int unsigned NUM_LANES = 16,
  parameter int unsigned RUN_W     = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           beat,
  input  logic                           is_zero,
  input  logic                           last,
  input  logic [3:0]                     bitwidth,
  output logic                           wr,
  output logic [$clog2(NUM_LANES)-1:0]   lane,
  output logic [RUN_W-1:0]               index,
  output logic                           close,
  output logic [$clog2(NUM_LANES):0]     count
);

  localparam int unsigned LANE_W = $clog2(NUM_LANES);
  localparam int unsigned CNT_W  = $clog2(NUM_LANES) + 1;

  logic [CNT_W-1:0]  g_q;
  logic [CNT_W-1:0]  g;
  logic [LANE_W-1:0] lane_q;
  logic [RUN_W-1:0]  cur_q;
  logic              tile_active_q;
  logic              lane_full;

  always_comb begin
    // The first beat of a tile uses the freshly sampled bitwidth.
    g         = tile_active_q ? g_q : CNT_W'(group_size(bitwidth));
    lane_full = (CNT_W'(lane_q) == g - CNT_W'(1));
    // A saturated run forces a zero-valued filler entry, except on the closing beat.
    wr        = beat && (!is_zero || ((cur_q == '1) && !last));
    close     = beat && (last || (wr && lane_full));
    count     = CNT_W'(lane_q) + CNT_W'(wr);
    lane      = lane_q;
    index     = cur_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      g_q           <= '0;
      lane_q        <= '0;
      cur_q         <= '0;
      tile_active_q <= 1'b0;
    end else if (beat) begin
      if (last) begin
        tile_active_q <= 1'b0;
        lane_q        <= '0;
        cur_q         <= '0;
      end else begin
        tile_active_q <= 1'b1;
        g_q           <= g;
        if (wr) begin
          if (lane_full) begin
            lane_q <= '0;
            cur_q  <= RUN_W'(1);
          end else begin
            lane_q <= lane_q + LANE_W'(1);
            cur_q  <= '0;
          end
        end else begin
          cur_q <= cur_q + RUN_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/sparse_index_encoder.sv
// Dense-to-sparse encoder: packs non-zero elements with run indices into lane groups.
module sparse_index_encoder #(
  parameter int unsigned DATA_W = bitfuscnn_pkg::DATA_W,
  parameter int unsigned LANES  = bitfuscnn_pkg::LANES,
  parameter int unsigned IDX_W  = bitfuscnn_pkg::IDX_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [3:0]                bitwidth,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*DATA_W-1:0]   out_values,
  output logic [LANES*IDX_W-1:0]    out_indices,
  output logic [$clog2(LANES):0]    out_count,
  output logic                      out_last
);

  localparam int unsigned LANE_W = $clog2(LANES);
  localparam int unsigned CNT_W  = $clog2(LANES) + 1;

  logic                    beat;
  logic                    wr;
  logic                    close;
  logic [LANE_W-1:0]       wr_lane;
  logic [IDX_W-1:0]        wr_index;
  logic [CNT_W-1:0]        close_count;
  logic [LANES*DATA_W-1:0] stage_values_q;
  logic [LANES*IDX_W-1:0]  stage_indices_q;
  logic [LANES*DATA_W-1:0] merged_values;
  logic [LANES*IDX_W-1:0]  merged_indices;

  assign in_ready = !out_valid || out_ready;
  assign beat     = in_valid && in_ready;

  sparse_run_counter #(
    .NUM_LANES (LANES),
    .RUN_W     (IDX_W)
  ) u_run_counter (
    .clk      (clk),
    .reset    (reset),
    .beat     (beat),
    .is_zero  (in_data == '0),
    .last     (in_last),
    .bitwidth (bitwidth),
    .wr       (wr),
    .lane     (wr_lane),
    .index    (wr_index),
    .close    (close),
    .count    (close_count)
  );

  // Staged group with this beat's entry folded in; placeholders carry in_data == 0.
  always_comb begin
    merged_values  = stage_values_q;
    merged_indices = stage_indices_q;
    if (wr) begin
      merged_values[wr_lane*DATA_W +: DATA_W] = in_data;
      merged_indices[wr_lane*IDX_W +: IDX_W]  = wr_index;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_values_q  <= '0;
      stage_indices_q <= '0;
      out_valid       <= 1'b0;
      out_values      <= '0;
      out_indices     <= '0;
      out_count       <= '0;
      out_last        <= 1'b0;
    end else begin
      if (close) begin
        stage_values_q  <= '0;
        stage_indices_q <= '0;
      end else if (wr) begin
        stage_values_q  <= merged_values;
        stage_indices_q <= merged_indices;
      end

      // close implies in_ready, so the output register is free or draining now.
      if (close) begin
        out_valid   <= 1'b1;
        out_values  <= merged_values;
        out_indices <= merged_indices;
        out_count   <= close_count;
        out_last    <= in_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sparse_index_encoder.sv
// Randomized and directed bench for sparse_index_encoder against a position-based reference model.
module tb_sparse_index_encoder;

  localparam int DATA_W = 16;
  localparam int LANES  = 16;
  localparam int IDX_W  = 4;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic [3:0]              bitwidth = '0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [DATA_W-1:0]       in_data = '0;
  logic                    in_last = 1'b0;
  logic                    out_valid;
  logic                    out_ready = 1'b1;
  logic [LANES*DATA_W-1:0] out_values;
  logic [LANES*IDX_W-1:0]  out_indices;
  logic [4:0]              out_count;
  logic                    out_last;

  typedef struct {
    logic [255:0] v;
    logic [63:0]  i;
    int           cnt;
    bit           last;
  } grp_t;

  grp_t exp_q[$];
  grp_t got_q[$];
  grp_t mon_got, mon_exp, r, r2;
  int   n_checks = 0;
  int   n_fail = 0;
  int   rdy_mode = 2;  // 0 random, 1 hold low, 2 hold high

  sparse_index_encoder dut (
    .clk         (clk),
    .reset       (reset),
    .bitwidth    (bitwidth),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_values  (out_values),
    .out_indices (out_indices),
    .out_count   (out_count),
    .out_last    (out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int gsz(input int bw);
    return (bw == 2) ? 8 : (bw == 3) ? 4 : 16;
  endfunction

  // Index of an entry = distance from the previous entry's position, minus one except
  // for lane 0 of a non-first group. A zero whose index would reach 15 becomes a filler entry.
  task automatic model_tile(input int g, input logic [15:0] q[$]);
    grp_t cur;
    int prev = -1;
    bit first = 1'b1;
    int n = q.size();
    int d;
    cur.v = '0; cur.i = '0; cur.cnt = 0; cur.last = 1'b0;
    for (int p = 0; p < n; p++) begin
      d = p - prev - ((cur.cnt == 0 && !first) ? 0 : 1);
      if (q[p] != 0 || (d == 15 && p != n - 1)) begin
        cur.v[cur.cnt*16 +: 16] = q[p];
        cur.i[cur.cnt*4 +: 4]   = d[3:0];
        cur.cnt++;
        prev = p;
      end
      if (cur.cnt == g || p == n - 1) begin
        cur.last = (p == n - 1);
        exp_q.push_back(cur);
        cur.v = '0; cur.i = '0; cur.cnt = 0; cur.last = 1'b0;
        first = 1'b0;
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = ($urandom_range(0, 3) != 0);
      1:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  end

  always @(negedge clk) begin
    if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
      mon_got.v = out_values; mon_got.i = out_indices;
      mon_got.cnt = int'(out_count); mon_got.last = out_last;
      got_q.push_back(mon_got);
      check("group_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        check("values", out_values, mon_exp.v);
        check("indices", out_indices, mon_exp.i);
        check("count", out_count, mon_exp.cnt);
        check("last", out_last, mon_exp.last);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic drive_beat(input logic [15:0] d, input logic l);
    int  n = 0;
    bit  acc;
    in_valid = 1'b1; in_data = d; in_last = l;
    do begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1; n++;
    end while (!acc && n < 500);
    check("beat_accept", acc, 1);
    in_valid = 1'b0;
  endtask

  task automatic run_tile(input int bw, input logic [15:0] q[$], input bit gaps);
    model_tile(gsz(bw), q);
    bitwidth = bw[3:0];
    for (int p = 0; p < q.size(); p++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      drive_beat(q[p], p == q.size() - 1);
      if (p == 0) bitwidth = 4'($urandom_range(0, 15));  // must be ignored mid-tile
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin @(posedge clk); #1; n++; end
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] q[$];
    int zp;

    repeat (3) @(posedge clk);
    #1; reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_count", out_count, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_values", out_values, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    q = '{0, 0, 5, 0, 7, 3, 0, 0, 9};
    run_tile(3, q, 0); wait_drain();
    r = got_q[got_q.size()-1];
    check("idx_pat_count", r.cnt, 4);
    check("idx_pat_values", r.v[63:0], {16'd9, 16'd3, 16'd7, 16'd5});
    check("idx_pat_indices", r.i[15:0], {4'd2, 4'd0, 4'd1, 4'd2});
    check("idx_pat_last", r.last, 1);

    q = {};
    repeat (20) q.push_back(16'd0);
    q.push_back(16'd4);
    run_tile(1, q, 0); wait_drain();
    r = got_q[got_q.size()-1];
    check("ph_count", r.cnt, 2);
    check("ph_values", r.v[31:0], {16'd4, 16'd0});
    check("ph_indices", r.i[7:0], {4'd4, 4'd15});
    check("ph_last", r.last, 1);

    q = {};
    for (int k = 1; k <= 9; k++) q.push_back(16'(k));
    run_tile(2, q, 0); wait_drain();
    r  = got_q[got_q.size()-2];
    r2 = got_q[got_q.size()-1];
    check("gb_g1_count", r.cnt, 8);
    check("gb_g1_indices", r.i, 0);
    check("gb_g1_last", r.last, 0);
    check("gb_g2_count", r2.cnt, 1);
    check("gb_g2_lane0", {r2.v[15:0], r2.i[3:0]}, {16'd9, 4'd1});
    check("gb_g2_last", r2.last, 1);

    q = {};
    repeat (10) q.push_back(16'd0);
    run_tile(0, q, 0); wait_drain();
    r = got_q[got_q.size()-1];
    check("zero_tile_count", r.cnt, 0);
    check("zero_tile_last", r.last, 1);

    // Backpressure with a full group held in the output register.
    rdy_mode = 1;
    repeat (3) begin @(posedge clk); #1; end
    q = '{1, 2, 3, 4, 5};
    model_tile(4, q);
    bitwidth = 4'd3;
    for (int p = 0; p < 4; p++) drive_beat(q[p], 1'b0);
    in_valid = 1'b1; in_data = 16'd5; in_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_values_stable", out_values, exp_q[0].v);
      check("bp_count_stable", out_count, exp_q[0].cnt);
      @(posedge clk); #1;
    end
    rdy_mode = 2;
    @(posedge clk); #2;
    @(negedge clk);
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_out_valid", out_valid, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_drain();

    // Reset mid-tile discards the partial group.
    bitwidth = 4'd1;
    drive_beat(16'd11, 1'b0);
    drive_beat(16'd12, 1'b0);
    drive_beat(16'd13, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", out_valid, 0);
    @(posedge clk); #1;
    q = '{0, 6};
    run_tile(1, q, 0); wait_drain();
    r = got_q[got_q.size()-1];
    check("mid_rst_count", r.cnt, 1);
    check("mid_rst_lane0", {r.v[15:0], r.i[3:0]}, {16'd6, 4'd1});

    rdy_mode = 0;
    for (int t = 0; t < 40; t++) begin
      q = {};
      case ($urandom_range(0, 2))
        0:       zp = 30;
        1:       zp = 70;
        default: zp = 95;
      endcase
      for (int k = $urandom_range(1, 40); k > 0; k--)
        q.push_back(($urandom_range(0, 99) < zp) ? 16'd0 : 16'($urandom_range(1, 65535)));
      run_tile($urandom_range(0, 15), q, 1);
    end
    rdy_mode = 2;
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
